// File: rtl/adc_decimator.sv
`default_nettype none
// ============================================================================
// Module   : adc_decimator
// Purpose  : Two-channel 8-bit sample-rate reducer (decimate / max / min / avg)
// Revision : 1.0  initial release
// ============================================================================
module adc_decimator #(
  parameter int DIV_W   = 24,
  parameter int AVG_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      din,
  input  logic [DIV_W-1:0] sample_divider,
  input  logic [1:0]       mode,
  input  logic [4:0]       avg_shift,
  input  logic             restart,
  output logic [15:0]      dout,
  output logic             dout_valid
);

  localparam int ACC_W = 8 + AVG_MAX;
  localparam int CNT_W = (DIV_W > AVG_MAX) ? DIV_W : AVG_MAX + 1;

  localparam logic [1:0] c_MODE_DEC = 2'd0;
  localparam logic [1:0] c_MODE_MAX = 2'd1;
  localparam logic [1:0] c_MODE_MIN = 2'd2;
  localparam logic [1:0] c_MODE_AVG = 2'd3;
  localparam logic [4:0] c_SHIFT_MAX = 5'(AVG_MAX);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_shift;
  logic [15:0]      r_dec;
  logic [7:0]       r_max_hi, r_max_lo, r_min_hi, r_min_lo;
  logic [ACC_W-1:0] r_sum_hi, r_sum_lo;

  logic             w_first, w_close;
  logic [1:0]       w_mode;
  logic [DIV_W-1:0] w_div;
  logic [4:0]       w_shift_in, w_shift;
  logic [CNT_W-1:0] w_last;
  logic [7:0]       w_din_hi, w_din_lo;
  logic [7:0]       w_max_hi, w_max_lo, w_min_hi, w_min_lo;
  logic [ACC_W-1:0] w_sum_hi, w_sum_lo;
  logic [15:0]      w_dec, w_result;

  // At cnt=0 the live config governs the window that is just starting,
  // so an L=1 window can close on the very sample that latches it.
  assign w_first    = (r_cnt == '0);
  assign w_shift_in = (avg_shift > c_SHIFT_MAX) ? c_SHIFT_MAX : avg_shift;
  assign w_mode     = w_first ? mode : r_mode;
  assign w_div      = w_first ? sample_divider : r_div;
  assign w_shift    = w_first ? w_shift_in : r_shift;
  assign w_last     = (w_mode == c_MODE_AVG) ? ((CNT_W'(1) << w_shift) - CNT_W'(1))
                                             : CNT_W'(w_div);
  assign w_close    = (r_cnt == w_last);

  assign w_din_hi = din[15:8];
  assign w_din_lo = din[7:0];
  assign w_dec    = w_first ? din : r_dec;
  assign w_max_hi = (w_first || (w_din_hi > r_max_hi)) ? w_din_hi : r_max_hi;
  assign w_max_lo = (w_first || (w_din_lo > r_max_lo)) ? w_din_lo : r_max_lo;
  assign w_min_hi = (w_first || (w_din_hi < r_min_hi)) ? w_din_hi : r_min_hi;
  assign w_min_lo = (w_first || (w_din_lo < r_min_lo)) ? w_din_lo : r_min_lo;
  assign w_sum_hi = w_first ? ACC_W'(w_din_hi) : r_sum_hi + ACC_W'(w_din_hi);
  assign w_sum_lo = w_first ? ACC_W'(w_din_lo) : r_sum_lo + ACC_W'(w_din_lo);

  always_comb begin
    w_result = w_dec;
    case (w_mode)
      c_MODE_DEC: w_result = w_dec;
      c_MODE_MAX: w_result = {w_max_hi, w_max_lo};
      c_MODE_MIN: w_result = {w_min_hi, w_min_lo};
      c_MODE_AVG: w_result = {8'(w_sum_hi >> w_shift), 8'(w_sum_lo >> w_shift)};
      default:    w_result = w_dec;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_mode     <= c_MODE_DEC;
      r_div      <= '0;
      r_shift    <= '0;
      r_dec      <= '0;
      r_max_hi   <= 8'h00;
      r_max_lo   <= 8'h00;
      r_min_hi   <= 8'hFF;
      r_min_lo   <= 8'hFF;
      r_sum_hi   <= '0;
      r_sum_lo   <= '0;
      dout       <= 16'h0000;
      dout_valid <= 1'b0;
    end else if (restart) begin
      r_cnt      <= '0;
      r_dec      <= '0;
      r_max_hi   <= 8'h00;
      r_max_lo   <= 8'h00;
      r_min_hi   <= 8'hFF;
      r_min_lo   <= 8'hFF;
      r_sum_hi   <= '0;
      r_sum_lo   <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (w_first) begin
        r_mode  <= mode;
        r_div   <= sample_divider;
        r_shift <= w_shift_in;
      end
      r_dec    <= w_dec;
      r_max_hi <= w_max_hi;
      r_max_lo <= w_max_lo;
      r_min_hi <= w_min_hi;
      r_min_lo <= w_min_lo;
      r_sum_hi <= w_sum_hi;
      r_sum_lo <= w_sum_lo;
      if (w_close) begin
        r_cnt      <= '0;
        dout       <= w_result;
        dout_valid <= 1'b1;
      end else begin
        r_cnt      <= r_cnt + CNT_W'(1);
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_decimator
// Purpose  : Self-checking bench for adc_decimator (vectors, sequences, random)
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_decimator;

  logic        clk = 1'b0;
  logic        rst, restart;
  logic [15:0] din;
  logic [23:0] div;
  logic [1:0]  mode;
  logic [4:0]  shift;
  logic [15:0] dout;
  logic        dout_valid;

  always #5 clk = ~clk;

  adc_decimator #(.DIV_W(24), .AVG_MAX(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .din            (din),
    .sample_divider (div),
    .mode           (mode),
    .avg_shift      (shift),
    .restart        (restart),
    .dout           (dout),
    .dout_valid     (dout_valid)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference: a window is the list of accepted samples; it closes when the
  // list reaches the length chosen by the config seen at its first sample.
  logic [15:0] q[$];
  logic [1:0]  m_mode;
  int          m_len;
  int          m_shift;
  logic [15:0] exp_dout  = 16'h0000;
  logic        exp_valid = 1'b0;

  typedef struct {
    logic [1:0]  mode;
    int          div;
    int          shift;
    int          len;
    logic [15:0] s[8];
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] window_result();
    int hi, lo;
    if (m_mode == 2'd0) return q[0];
    hi = (m_mode == 2'd2) ? 255 : 0;
    lo = hi;
    foreach (q[i]) begin
      case (m_mode)
        2'd1: begin
          if (int'(q[i][15:8]) > hi) hi = int'(q[i][15:8]);
          if (int'(q[i][7:0])  > lo) lo = int'(q[i][7:0]);
        end
        2'd2: begin
          if (int'(q[i][15:8]) < hi) hi = int'(q[i][15:8]);
          if (int'(q[i][7:0])  < lo) lo = int'(q[i][7:0]);
        end
        default: begin
          hi += int'(q[i][15:8]);
          lo += int'(q[i][7:0]);
        end
      endcase
    end
    if (m_mode == 2'd3) begin
      hi = (hi >> m_shift) & 255;
      lo = (lo >> m_shift) & 255;
    end
    return {8'(hi), 8'(lo)};
  endfunction

  task automatic model_update();
    if (rst) begin
      q.delete();
      exp_dout  = 16'h0000;
      exp_valid = 1'b0;
    end else if (restart) begin
      q.delete();
      exp_valid = 1'b0;
    end else begin
      if (q.size() == 0) begin
        m_mode  = mode;
        m_shift = (int'(shift) > 16) ? 16 : int'(shift);
        m_len   = (mode == 2'd3) ? (1 << m_shift) : int'(div) + 1;
      end
      q.push_back(din);
      if (q.size() == m_len) begin
        exp_dout  = window_result();
        exp_valid = 1'b1;
        q.delete();
      end else begin
        exp_valid = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("model_valid", dout_valid, exp_valid);
    chk("model_dout", dout, exp_dout);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    din     = 16'hDEAD;
    step();
    chk("restart_valid", dout_valid, 1'b0);
    restart = 1'b0;
  endtask

  initial begin
    int strobes;

    tbl[0].mode = 2'd1; tbl[0].div = 4; tbl[0].shift = 0; tbl[0].len = 5;
    tbl[0].s = '{16'h107F, 16'h8000, 16'hFF81, 16'h0380, 16'h2001, 0, 0, 0};
    tbl[0].exp = 16'hFF81;
    tbl[1].mode = 2'd2; tbl[1].div = 4; tbl[1].shift = 0; tbl[1].len = 5;
    tbl[1].s = '{16'h107F, 16'h8000, 16'hFF81, 16'h0380, 16'h2001, 0, 0, 0};
    tbl[1].exp = 16'h0300;
    // hi: (255*3+254)/4 = 254.75 -> FE ; lo: 3/4 -> 00
    tbl[2].mode = 2'd3; tbl[2].div = 9; tbl[2].shift = 2; tbl[2].len = 4;
    tbl[2].s = '{16'hFF01, 16'hFF01, 16'hFF01, 16'hFE00, 0, 0, 0, 0};
    tbl[2].exp = 16'hFE00;
    tbl[3].mode = 2'd0; tbl[3].div = 3; tbl[3].shift = 0; tbl[3].len = 4;
    tbl[3].s = '{16'h1234, 16'hFFFF, 16'h0000, 16'h5555, 0, 0, 0, 0};
    tbl[3].exp = 16'h1234;
    tbl[4].mode = 2'd3; tbl[4].div = 0; tbl[4].shift = 3; tbl[4].len = 8;
    tbl[4].s = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10};
    tbl[4].exp = 16'h0809;
    tbl[5].mode = 2'd1; tbl[5].div = 0; tbl[5].shift = 0; tbl[5].len = 1;
    tbl[5].s = '{16'h00FF, 0, 0, 0, 0, 0, 0, 0};
    tbl[5].exp = 16'h00FF;
    tbl[6].mode = 2'd2; tbl[6].div = 2; tbl[6].shift = 0; tbl[6].len = 3;
    tbl[6].s = '{16'h80FF, 16'h7F00, 16'hFF01, 0, 0, 0, 0, 0};
    tbl[6].exp = 16'h7F00;

    rst = 1'b1; restart = 1'b0; din = 16'h0000; div = 24'd0; mode = 2'd0; shift = 5'd0;
    repeat (3) step();
    chk("reset_dout", dout, 16'h0000);
    chk("reset_valid", dout_valid, 1'b0);
    rst = 1'b0;

    // L=1 pass-through
    for (int k = 0; k < 8; k++) begin
      din = 16'(k * 16'h0101);
      step();
      chk("pass_valid", dout_valid, 1'b1);
      chk("pass_dout", dout, 16'(k * 16'h0101));
    end

    // Decimate by 4
    div = 24'd3;
    do_restart();
    for (int k = 0; k < 16; k++) begin
      din = 16'(k * 16'h0101);
      step();
      chk("dec_valid", dout_valid, (k % 4) == 3);
      if ((k % 4) == 3) chk("dec_dout", dout, 16'((k - 3) * 16'h0101));
    end

    // Vector table
    foreach (tbl[t]) begin
      mode = tbl[t].mode; div = 24'(tbl[t].div); shift = 5'(tbl[t].shift);
      do_restart();
      for (int k = 0; k < tbl[t].len; k++) begin
        din = tbl[t].s[k];
        step();
        chk("tbl_valid", dout_valid, k == tbl[t].len - 1);
      end
      chk("tbl_dout", dout, tbl[t].exp);
    end

    // restart at cnt=5 suppresses the old close
    mode = 2'd0; div = 24'd7; shift = 5'd0;
    do_restart();
    for (int k = 0; k < 5; k++) begin
      din = 16'(16'h1100 + k);
      step();
    end
    do_restart();
    for (int k = 0; k < 8; k++) begin
      din = 16'(16'h2200 + k);
      step();
      chk("rst_win_valid", dout_valid, k == 7);
    end
    chk("rst_win_dout", dout, 16'h2200);

    // divider change mid-window takes effect at the next window
    for (int k = 0; k < 8; k++) begin
      if (k == 3) div = 24'd1;
      din = 16'(16'h3300 + k);
      step();
      chk("cfg_old_valid", dout_valid, k == 7);
    end
    chk("cfg_old_dout", dout, 16'h3300);
    for (int j = 0; j < 6; j++) begin
      din = 16'(16'h4400 + j);
      step();
      chk("cfg_new_valid", dout_valid, (j % 2) == 1);
      if ((j % 2) == 1) chk("cfg_new_dout", dout, 16'(16'h4400 + j - 1));
    end

    // reset mid-window discards captured peak
    mode = 2'd1; div = 24'd9;
    do_restart();
    for (int k = 0; k < 6; k++) begin
      din = (k == 2) ? 16'hFFFF : 16'(k * 16'h0101);
      step();
    end
    rst = 1'b1; din = 16'hEEEE;
    step();
    chk("midrst_valid", dout_valid, 1'b0);
    chk("midrst_dout", dout, 16'h0000);
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      din = 16'(16'h1000 + j * 16'h0101);
      step();
      chk("postrst_valid", dout_valid, j == 9);
    end
    chk("postrst_max", dout, 16'h1909);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        mode  = 2'($urandom);
        div   = 24'($urandom_range(0, 5));
        shift = 5'($urandom_range(0, 3));
      end
      restart = ($urandom_range(0, 29) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      din     = 16'($urandom);
      step();
    end
    rst = 1'b0; restart = 1'b0;

    // Clamped shift: 31 -> 16, window of 65536 samples
    mode = 2'd3; shift = 5'd31; div = 24'd2;
    do_restart();
    strobes = 0;
    din = 16'hA05F;
    for (int k = 0; k < 65536; k++) begin
      step();
      if (dout_valid) strobes++;
    end
    chk("clamp_last_valid", dout_valid, 1'b1);
    chk("clamp_strobes", strobes, 1);
    chk("clamp_dout", dout, 16'hA05F);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
